uart_rx: RTL and testbench

Serial UART receiver that sits directly downstream of the team's UART transmitter (`CEP`) and consumes its `Tx` line. It deserialises 8N1 frames (start bit 0, 8 data bits LSB first, stop bit 1) at a fixed clocks-per-bit rate. It presents each received byte in a holding register with a valid/ack handshake, and flags framing and overrun errors. Typical use is loopback verification of `CEP` and the receive half of the lab UART.

---
 rtl/uart_rx.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with a valid/ack holding register.
//
// Deserialises frames from a UART transmitter line: start bit 0,
// 8 data bits LSB first, stop bit 1, at CLKS_PER_BIT clocks per bit.
// Received bytes land in a holding register. Framing and overrun
// errors are flagged.
//
// Optional feature macro: UART_RX_PARITY_EN
//   When defined, an even-parity bit follows the data bits and the
//   parity_err port exists.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 4)
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   Rx          serial input, idles high, asynchronous to clk
//   rx_ack      consumer acknowledges data_out
//   data_out    last received byte
//   rx_valid    data_out holds an unacknowledged byte
//   frame_err   one-cycle pulse when the stop bit samples 0
//   overrun     a completed byte was dropped while rx_valid was set
//   parity_err  one-cycle pulse on parity mismatch (macro only)
//   busy        high while a frame is in progress
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx,
    input  logic       rx_ack,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            sync_a;
    logic            rx_s;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            stop_done;
    logic            stop_bit;
    logic            cnt_clr;
    logic            data_en;
    logic            stop_en;
    logic            commit;
`ifdef UART_RX_PARITY_EN
    logic            par_en;
    logic            par_bit;
`endif

    // Two-flop synchronizer; idles high so reset cannot fake a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_a <= Rx;
            rx_s   <= sync_a;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Every sample point also clears the bit counter,
    // so each state times its interval from its own entry.
    always_comb begin
        next_state = state;
        cnt_clr    = 1'b0;
        data_en    = 1'b0;
        stop_en    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en     = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!rx_s) begin
                    next_state = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_clr    = 1'b1;
                    next_state = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_clr = 1'b1;
                    data_en = 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        next_state = PARITY;
`else
                        next_state = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == FULL_LAST) begin
                    cnt_clr    = 1'b1;
                    par_en     = 1'b1;
                    next_state = STOP;
                end
            end
`endif
            STOP: begin
                // Leave at mid-stop-bit so a back-to-back start edge is seen.
                if (cnt == FULL_LAST) begin
                    cnt_clr    = 1'b1;
                    stop_en    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                cnt_clr    = 1'b1;
                next_state = IDLE;
            end
        endcase
    end

    // Bit timing counter, data shifter and the registered stop-bit result
    // that drives the commit one cycle after the stop sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            stop_done <= 1'b0;
            stop_bit  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            cnt <= cnt_clr ? '0 : cnt + 1'b1;
            if (state == START) begin
                bit_idx <= '0;
            end else if (data_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (data_en) begin
                shift <= {rx_s, shift[7:1]};
            end
`ifdef UART_RX_PARITY_EN
            if (par_en) begin
                par_bit <= rx_s;
            end
`endif
            stop_done <= stop_en;
            if (stop_en) begin
                stop_bit <= rx_s;
            end
        end
    end

    assign commit = stop_done && stop_bit;

    // Holding register and flags. A commit takes priority over an ack;
    // an ack arriving with a commit frees the slot for the new byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out   <= 8'h00;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= stop_done && !stop_bit;
            busy      <= (state != IDLE);
`ifdef UART_RX_PARITY_EN
            parity_err <= stop_done && (par_bit != ^shift);
`endif
            if (commit) begin
                if (!rx_valid || rx_ack) begin
                    data_out <= shift;
                    rx_valid <= 1'b1;
                    overrun  <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ack) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed, table-driven bench for uart_rx at CLKS_PER_BIT=16.
//
// Frames are driven bit-serially on Rx; outputs are snapshotted around
// the commit edge and compared against hand-computed expectations.
// Honours UART_RX_PARITY_EN for the parity bit and the parity_err port.
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // Edge (counted from the edge after which the start bit is driven)
    // at which the byte is committed: t=3, stop sample t+8+(NB-1)*16, +1.
    localparam int COMMIT = 3 + CPB / 2 + (NB - 1) * CPB + 1;

    logic       clk;
    logic       reset;
    logic       Rx;
    logic       rx_ack;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int total;
    int passed;

    logic       snap_valid_pre;
    logic       snap_busy_pre;
    logic       snap_ferr_pre;
    logic       snap_valid;
    logic [7:0] snap_data;
    logic       snap_ferr;
    logic       snap_busy;
    logic       snap_ovr;
    logic       snap_ferr_post;
    logic       snap_perr;
    logic       snap_perr_post;

    typedef struct {
        logic [7:0] din;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[6];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .Rx        (Rx),
        .rx_ack    (rx_ack),
        .data_out  (data_out),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy      (busy)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        total = total + 1;
        if (act === exp) begin
            passed = passed + 1;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Serial frame image, bit 0 first on the line.
    function automatic logic [10:0] buildFrame(input logic [7:0] b, input logic stopv, input logic par);
        logic [10:0] f;
        f      = 11'h7FF;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_RX_PARITY_EN
        f[9]   = par;
        f[10]  = stopv;
`else
        f[9]   = stopv;
        f[10]  = par;
`endif
        return f;
    endfunction

    // Drives one whole frame and snapshots outputs around the commit edge.
    task automatic sendFrame(input logic [7:0] b, input logic stopv, input logic ack_at_commit, input logic par);
        logic [10:0] fb;
        fb = buildFrame(b, stopv, par);
        for (int n = 0; n < CPB * NB; n++) begin
            Rx     = fb[n / CPB];
            rx_ack = ack_at_commit && (n == COMMIT - 1);
            @(posedge clk);
            #1;
            if (n + 1 == COMMIT - 1) begin
                snap_valid_pre = rx_valid;
                snap_busy_pre  = busy;
                snap_ferr_pre  = frame_err;
            end
            if (n + 1 == COMMIT) begin
                snap_valid = rx_valid;
                snap_data  = data_out;
                snap_ferr  = frame_err;
                snap_busy  = busy;
                snap_ovr   = overrun;
`ifdef UART_RX_PARITY_EN
                snap_perr  = parity_err;
`else
                snap_perr  = 1'b0;
`endif
            end
            if (n + 1 == COMMIT + 1) begin
                snap_ferr_post = frame_err;
`ifdef UART_RX_PARITY_EN
                snap_perr_post = parity_err;
`else
                snap_perr_post = 1'b0;
`endif
            end
        end
        Rx     = 1'b1;
        rx_ack = 1'b0;
    endtask

    task automatic pulseAck(input string name);
        rx_ack = 1'b1;
        idleCycles(1);
        rx_ack = 1'b0;
        checkOutput({name, "_ack_valid"}, {7'd0, rx_valid}, 8'd0);
        checkOutput({name, "_ack_ovr"}, {7'd0, overrun}, 8'd0);
    endtask

    // One table entry: an isolated frame from a cleared holding register.
    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        sendFrame(v.din, v.stop, 1'b0, ^v.din);
        idleCycles(24);
        checkOutput({tag, "_valid_pre"}, {7'd0, snap_valid_pre}, 8'd0);
        checkOutput({tag, "_busy_pre"}, {7'd0, snap_busy_pre}, 8'd1);
        checkOutput({tag, "_ferr_pre"}, {7'd0, snap_ferr_pre}, 8'd0);
        checkOutput({tag, "_valid"}, {7'd0, snap_valid}, {7'd0, v.exp_valid});
        checkOutput({tag, "_data"}, snap_data, v.exp_data);
        checkOutput({tag, "_ferr"}, {7'd0, snap_ferr}, {7'd0, v.exp_ferr});
        checkOutput({tag, "_ferr_post"}, {7'd0, snap_ferr_post}, 8'd0);
        checkOutput({tag, "_busy"}, {7'd0, snap_busy}, 8'd0);
        checkOutput({tag, "_busy_idle"}, {7'd0, busy}, 8'd0);
        if (v.exp_valid) begin
            pulseAck(tag);
        end
    endtask

    initial begin
        logic [10:0] fb;
        total  = 0;
        passed = 0;
        reset  = 1'b1;
        Rx     = 1'b1;
        rx_ack = 1'b0;

        vecs[0] = '{8'h0F, 1'b1, 8'h0F, 1'b1, 1'b0};
        vecs[1] = '{8'hA5, 1'b0, 8'h0F, 1'b0, 1'b1};
        vecs[2] = '{8'h80, 1'b1, 8'h80, 1'b1, 1'b0};
        vecs[3] = '{8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[4] = '{8'h5A, 1'b0, 8'h01, 1'b0, 1'b1};
        vecs[5] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        idleCycles(3);
        reset = 1'b0;
        idleCycles(1);
        checkOutput("rst_data", data_out, 8'h00);
        checkOutput("rst_valid", {7'd0, rx_valid}, 8'd0);
        checkOutput("rst_ferr", {7'd0, frame_err}, 8'd0);
        checkOutput("rst_ovr", {7'd0, overrun}, 8'd0);
        checkOutput("rst_busy", {7'd0, busy}, 8'd0);
`ifdef UART_RX_PARITY_EN
        checkOutput("rst_perr", {7'd0, parity_err}, 8'd0);
`endif
        idleCycles(4);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], i);
        end

        // False start: three low cycles; start sample at t+8 sees high.
        Rx = 1'b0;
        idleCycles(3);
        Rx = 1'b1;
        idleCycles(8);
        checkOutput("fs_busy_t8", {7'd0, busy}, 8'd1);
        idleCycles(1);
        checkOutput("fs_busy_t9", {7'd0, busy}, 8'd0);
        idleCycles(10);
        checkOutput("fs_valid", {7'd0, rx_valid}, 8'd0);
        checkOutput("fs_ferr", {7'd0, frame_err}, 8'd0);

        // Back-to-back without ack: second byte dropped, overrun set.
        sendFrame(8'h11, 1'b1, 1'b0, ^8'h11);
        checkOutput("b2b_first_valid", {7'd0, snap_valid}, 8'd1);
        checkOutput("b2b_first_data", snap_data, 8'h11);
        sendFrame(8'h22, 1'b1, 1'b0, ^8'h22);
        checkOutput("b2b_data", snap_data, 8'h11);
        checkOutput("b2b_valid", {7'd0, snap_valid}, 8'd1);
        checkOutput("b2b_ovr", {7'd0, snap_ovr}, 8'd1);
        idleCycles(5);
        pulseAck("b2b");

        // Back-to-back with ack in the second commit cycle.
        sendFrame(8'h11, 1'b1, 1'b0, ^8'h11);
        sendFrame(8'h22, 1'b1, 1'b1, ^8'h22);
        checkOutput("b2back_data", snap_data, 8'h22);
        checkOutput("b2back_valid", {7'd0, snap_valid}, 8'd1);
        checkOutput("b2back_ovr", {7'd0, snap_ovr}, 8'd0);
        idleCycles(5);

        // Reset during data bit 4 of 0x3C, with 0x22 still held.
        fb = buildFrame(8'h3C, 1'b1, ^8'h3C);
        for (int n = 0; n < 88; n++) begin
            Rx = fb[n / CPB];
            idleCycles(1);
        end
        checkOutput("mid_busy", {7'd0, busy}, 8'd1);
        reset = 1'b1;
        Rx    = 1'b1;
        idleCycles(1);
        reset = 1'b0;
        checkOutput("mrst_data", data_out, 8'h00);
        checkOutput("mrst_valid", {7'd0, rx_valid}, 8'd0);
        checkOutput("mrst_ferr", {7'd0, frame_err}, 8'd0);
        checkOutput("mrst_ovr", {7'd0, overrun}, 8'd0);
        checkOutput("mrst_busy", {7'd0, busy}, 8'd0);
        idleCycles(1);
        checkOutput("mrst_idle", {7'd0, busy}, 8'd0);
        idleCycles(20);
        sendFrame(8'h3C, 1'b1, 1'b0, ^8'h3C);
        checkOutput("after_rst_valid", {7'd0, snap_valid}, 8'd1);
        checkOutput("after_rst_data", snap_data, 8'h3C);
        checkOutput("after_rst_ferr", {7'd0, snap_ferr}, 8'd0);
        idleCycles(5);
        pulseAck("after_rst");

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the parity bit must be 1.
        sendFrame(8'h07, 1'b1, 1'b0, 1'b1);
        checkOutput("par_ok_valid", {7'd0, snap_valid}, 8'd1);
        checkOutput("par_ok_data", snap_data, 8'h07);
        checkOutput("par_ok_perr", {7'd0, snap_perr}, 8'd0);
        idleCycles(5);
        pulseAck("par_ok");
        sendFrame(8'h07, 1'b1, 1'b0, 1'b0);
        checkOutput("par_bad_perr", {7'd0, snap_perr}, 8'd1);
        checkOutput("par_bad_perr_post", {7'd0, snap_perr_post}, 8'd0);
        checkOutput("par_bad_data", snap_data, 8'h07);
        checkOutput("par_bad_valid", {7'd0, snap_valid}, 8'd1);
        idleCycles(5);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
